regfile_sequencer: RTL and testbench

//  Multi-cycle instruction sequencer that sits directly upstream of the 16x32 register file.

---
 rtl/regfile_sequencer_if.sv | 59 +++++
 rtl/regfile_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - instruction handshake and register file bus for the sequencer
//
// Purpose: groups the instruction valid/ready handshake, the retire status
//          and the 16-entry register file read/write port into one bundle.
// Ports (signals):
//   in_valid, in_instr[31:0], in_ready   instruction handshake
//   done, err                            retire pulse and illegal qualifier
//   rf_en, rf_rd, rf_wr                  register file controls
//   rf_sel_o1, rf_sel_o2, rf_sel_i1      read selects (rs1, rs2) and write select (rd)
//   rf_ip                                write data
//   rf_op1, rf_op2                       read data returned by the register file
//   flags[3:0]                           {N,Z,C,V}, only when SEQ_FLAGS_EN is defined
// Modports: slave = the sequencer, master = upstream/register file side.
// Configuration macro: SEQ_FLAGS_EN.
interface regfile_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              done;
  logic              err;
  logic              rf_en;
  logic              rf_rd;
  logic              rf_wr;
  logic [3:0]        rf_sel_o1;
  logic [3:0]        rf_sel_o2;
  logic [3:0]        rf_sel_i1;
  logic [DATA_W-1:0] rf_ip;
  logic [DATA_W-1:0] rf_op1;
  logic [DATA_W-1:0] rf_op2;
`ifdef SEQ_FLAGS_EN
  logic [3:0]        flags;

  modport slave (
    input  in_valid, in_instr, rf_op1, rf_op2,
    output in_ready, done, err, rf_en, rf_rd, rf_wr,
    output rf_sel_o1, rf_sel_o2, rf_sel_i1, rf_ip, flags
  );

  modport master (
    output in_valid, in_instr, rf_op1, rf_op2,
    input  in_ready, done, err, rf_en, rf_rd, rf_wr,
    input  rf_sel_o1, rf_sel_o2, rf_sel_i1, rf_ip, flags
  );
`else
  modport slave (
    input  in_valid, in_instr, rf_op1, rf_op2,
    output in_ready, done, err, rf_en, rf_rd, rf_wr,
    output rf_sel_o1, rf_sel_o2, rf_sel_i1, rf_ip
  );

  modport master (
    output in_valid, in_instr, rf_op1, rf_op2,
    input  in_ready, done, err, rf_en, rf_rd, rf_wr,
    input  rf_sel_o1, rf_sel_o2, rf_sel_i1, rf_ip
  );
`endif
endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - non-pipelined instruction sequencer in front of a 16x32 register file
//
// Purpose: accepts one instruction per handshake, reads rs1/rs2 from the
//          register file, computes an ALU result and writes it back to rd.
//          Sequence is IDLE -> READ -> EXEC -> WB -> IDLE (one instruction per 4 cycles).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   regfile_sequencer_if.slave (handshake, retire status, register file port)
// Parameters:
//   DATA_W      datapath width, equal to the register file width
//   IMM_SIGNED  1: ADDI sign-extends imm[15:0], 0: zero-extends
// Configuration macro: SEQ_FLAGS_EN adds bus.flags = {N,Z,C,V}, updated at the
//   end of WB for ADD/SUB/ADDI.
module regfile_sequencer #(
  parameter int DATA_W     = 32,
  parameter bit IMM_SIGNED = 1'b1
) (
  input logic                clk,
  input logic                rst,
  regfile_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LUI  = 4'd9;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              in_ready_q, in_ready_d;
  logic              rf_en_q, rf_en_d;
  logic              rf_rd_q, rf_rd_d;
  logic              rf_wr_q, rf_wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [3:0]        sel_o1_q, sel_o1_d;
  logic [3:0]        sel_o2_q, sel_o2_d;
  logic [3:0]        sel_i1_q, sel_i1_d;
  logic [DATA_W-1:0] ip_q, ip_d;

  logic [3:0]        opcode;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_wen;
  logic              alu_illegal;

  assign opcode = instr_q[31:28];
  assign imm    = instr_q[15:0];

  always_comb begin
    imm_ext = IMM_SIGNED ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};
  end

  // ALU is evaluated only while in EXEC, when rf_op1/rf_op2 are valid.
  always_comb begin
    alu_res     = '0;
    alu_wen     = 1'b1;
    alu_illegal = 1'b0;
    case (opcode)
      OP_NOP:  alu_wen = 1'b0;
      OP_ADD:  alu_res = bus.rf_op1 + bus.rf_op2;
      OP_SUB:  alu_res = bus.rf_op1 - bus.rf_op2;
      OP_AND:  alu_res = bus.rf_op1 & bus.rf_op2;
      OP_OR:   alu_res = bus.rf_op1 | bus.rf_op2;
      OP_XOR:  alu_res = bus.rf_op1 ^ bus.rf_op2;
      OP_SHL:  alu_res = bus.rf_op1 << bus.rf_op2[4:0];
      OP_SHR:  alu_res = bus.rf_op1 >> bus.rf_op2[4:0];
      OP_ADDI: alu_res = bus.rf_op1 + imm_ext;
      OP_LUI:  alu_res = DATA_W'({imm, 16'h0000});
      default: begin
        alu_wen     = 1'b0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  // Next-state and next-output decode; every output is registered so it
  // reflects the state being entered.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    in_ready_d = 1'b0;
    rf_en_d    = 1'b0;
    rf_rd_d    = 1'b0;
    rf_wr_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sel_o1_d   = sel_o1_q;
    sel_o2_d   = sel_o2_q;
    sel_i1_d   = sel_i1_q;
    ip_d       = ip_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          instr_d    = bus.in_instr;
          state_d    = S_READ;
          in_ready_d = 1'b0;
          rf_en_d    = 1'b1;
          rf_rd_d    = 1'b1;
          sel_o1_d   = bus.in_instr[23:20];
          sel_o2_d   = bus.in_instr[19:16];
        end
      end
      S_READ: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d  = S_WB;
        rf_en_d  = 1'b1;
        rf_wr_d  = alu_wen;
        done_d   = 1'b1;
        err_d    = alu_illegal;
        sel_i1_d = instr_q[27:24];
        ip_d     = alu_res;
      end
      S_WB: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      in_ready_q <= 1'b1;
      rf_en_q    <= 1'b0;
      rf_rd_q    <= 1'b0;
      rf_wr_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_o1_q   <= '0;
      sel_o2_q   <= '0;
      sel_i1_q   <= '0;
      ip_q       <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      in_ready_q <= in_ready_d;
      rf_en_q    <= rf_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_wr_q    <= rf_wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sel_o1_q   <= sel_o1_d;
      sel_o2_q   <= sel_o2_d;
      sel_i1_q   <= sel_i1_d;
      ip_q       <= ip_d;
    end
  end

  // While rst is high the register file must see EN so its clear takes
  // effect, and no handshake, write or retire may be presented.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.rf_en     = rf_en_q | rst;
  assign bus.rf_rd     = rf_rd_q & ~rst;
  assign bus.rf_wr     = rf_wr_q & ~rst;
  assign bus.done      = done_q & ~rst;
  assign bus.err       = err_q & ~rst;
  assign bus.rf_sel_o1 = sel_o1_q;
  assign bus.rf_sel_o2 = sel_o2_q;
  assign bus.rf_sel_i1 = sel_i1_q;
  assign bus.rf_ip     = ip_q;

`ifdef SEQ_FLAGS_EN
  logic [3:0]        flags_q, flags_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W:0]   add_w;

  // C and V need the operands, which are only valid in EXEC, so they are
  // captured there; N and Z are taken from the registered result in WB.
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    flags_d = flags_q;
    add_b   = (opcode == OP_ADDI) ? imm_ext : bus.rf_op2;
    add_w   = {1'b0, bus.rf_op1} + {1'b0, add_b};
    if (state_q == S_EXEC) begin
      if (opcode == OP_SUB) begin
        carry_d = (bus.rf_op1 < bus.rf_op2);
        ovf_d   = (bus.rf_op1[DATA_W-1] != bus.rf_op2[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != bus.rf_op1[DATA_W-1]);
      end else begin
        carry_d = add_w[DATA_W];
        ovf_d   = (bus.rf_op1[DATA_W-1] == add_b[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != bus.rf_op1[DATA_W-1]);
      end
    end
    if ((state_q == S_WB) &&
        ((opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ADDI))) begin
      flags_d = {ip_q[DATA_W-1], (ip_q == '0), carry_q, ovf_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - directed self-checking bench for regfile_sequencer
module tb_regfile_sequencer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  logic [31:0] regs [16];

  regfile_sequencer_if #(.DATA_W(32)) bus ();

  regfile_sequencer #(
    .DATA_W     (32),
    .IMM_SIGNED (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 16x32 register file: EN-gated clear, read capture, write.
  always @(posedge clk) begin
    if (rst && bus.rf_en) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (bus.rf_en && bus.rf_rd) begin
      bus.rf_op1 <= regs[bus.rf_sel_o1];
      bus.rf_op2 <= regs[bus.rf_sel_o2];
    end else if (bus.rf_en && bus.rf_wr) begin
      regs[bus.rf_sel_i1] <= bus.rf_ip;
    end
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an instruction and returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    for (int i = 0; i < 8 && !bus.in_ready; i++) tick();
    check("accept_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [31:0] instr, input logic exp_wr,
                      input logic [31:0] exp_ip, input logic exp_err);
    send(instr);
    check({tag, "_read_rd"}, {31'b0, bus.rf_rd}, 32'd1);
    tick();
    check({tag, "_exec_done"}, {31'b0, bus.done}, 32'd0);
    tick();
    check({tag, "_wb_done"}, {31'b0, bus.done}, 32'd1);
    check({tag, "_wb_err"}, {31'b0, bus.err}, {31'b0, exp_err});
    check({tag, "_wb_wr"}, {31'b0, bus.rf_wr}, {31'b0, exp_wr});
    if (exp_wr) begin
      check({tag, "_wb_sel_i1"}, {28'b0, bus.rf_sel_i1}, {28'b0, instr[27:24]});
      check({tag, "_wb_ip"}, bus.rf_ip, exp_ip);
    end
    tick();
    check({tag, "_idle_done"}, {31'b0, bus.done}, 32'd0);
  endtask

  logic [31:0] b2b_instr [3];
  logic [31:0] b2b_exp [3];

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;

    // Reset state
    tick();
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("rst_rf_en", {31'b0, bus.rf_en}, 32'd1);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_rf_wr", {31'b0, bus.rf_wr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("idle_rf_en", {31'b0, bus.rf_en}, 32'd0);
    check("idle_rf_ip", bus.rf_ip, 32'd0);
    check("idle_sel_i1", {28'b0, bus.rf_sel_i1}, 32'd0);

    // ADDI r1,r0,5 with explicit latency checks
    send(enc(4'd8, 4'd1, 4'd0, 4'd0, 16'd5));
    check("t1_read_en", {31'b0, bus.rf_en}, 32'd1);
    check("t1_read_rd", {31'b0, bus.rf_rd}, 32'd1);
    check("t1_read_sel_o1", {28'b0, bus.rf_sel_o1}, 32'd0);
    check("t1_read_done", {31'b0, bus.done}, 32'd0);
    tick();
    check("t1_exec_en", {31'b0, bus.rf_en}, 32'd0);
    check("t1_exec_done", {31'b0, bus.done}, 32'd0);
    tick();
    check("t1_wb_done", {31'b0, bus.done}, 32'd1);
    check("t1_wb_en", {31'b0, bus.rf_en}, 32'd1);
    check("t1_wb_wr", {31'b0, bus.rf_wr}, 32'd1);
    check("t1_wb_rd", {31'b0, bus.rf_rd}, 32'd0);
    check("t1_wb_sel_i1", {28'b0, bus.rf_sel_i1}, 32'd1);
    check("t1_wb_ip", bus.rf_ip, 32'd5);
    check("t1_wb_err", {31'b0, bus.err}, 32'd0);
    tick();
    check("t1_after_done", {31'b0, bus.done}, 32'd0);
    check("t1_after_ready", {31'b0, bus.in_ready}, 32'd1);

    // Arithmetic
    exec("addi_r2", enc(4'd8, 4'd2, 4'd0, 4'd0, 16'd7), 1'b1, 32'd7, 1'b0);
    exec("add_r3", enc(4'd1, 4'd3, 4'd1, 4'd2, 16'd0), 1'b1, 32'd12, 1'b0);
`ifdef SEQ_FLAGS_EN
    check("flags_add", {28'b0, bus.flags}, 32'h0);
`endif
    exec("sub_r4", enc(4'd2, 4'd4, 4'd1, 4'd2, 16'd0), 1'b1, 32'hFFFF_FFFE, 1'b0);
`ifdef SEQ_FLAGS_EN
    check("flags_sub", {28'b0, bus.flags}, 32'hA);
`endif
    exec("and_r10", enc(4'd3, 4'd10, 4'd1, 4'd2, 16'd0), 1'b1, 32'd5, 1'b0);
    exec("xor_r11", enc(4'd5, 4'd11, 4'd1, 4'd2, 16'd0), 1'b1, 32'd2, 1'b0);
    exec("addi_r2_36", enc(4'd8, 4'd2, 4'd0, 4'd0, 16'd36), 1'b1, 32'd36, 1'b0);
    exec("shl_r5", enc(4'd6, 4'd5, 4'd1, 4'd2, 16'd0), 1'b1, 32'd80, 1'b0);
    exec("lui_r6", enc(4'd9, 4'd6, 4'd0, 4'd0, 16'hABCD), 1'b1, 32'hABCD_0000, 1'b0);
    exec("shr_r8", enc(4'd7, 4'd8, 4'd6, 4'd1, 16'd0), 1'b1, 32'h055E_6800, 1'b0);
    exec("addi_neg", enc(4'd8, 4'd7, 4'd1, 4'd0, 16'hFFFF), 1'b1, 32'd4, 1'b0);
    exec("nop", enc(4'd0, 4'd3, 4'd0, 4'd0, 16'd0), 1'b0, 32'd0, 1'b0);

    // Illegal opcode, then confirm r3 still holds 12
    exec("illegal", enc(4'd12, 4'd3, 4'd0, 4'd0, 16'd0), 1'b0, 32'd0, 1'b1);
    exec("r3_kept", enc(4'd1, 4'd9, 4'd3, 4'd0, 16'd0), 1'b1, 32'd12, 1'b0);

    // Reset during EXEC discards the instruction
    send(enc(4'd1, 4'd3, 4'd1, 4'd2, 16'd0));
    tick();
    rst = 1'b1;
    #1;
    check("rstx_rf_en", {31'b0, bus.rf_en}, 32'd1);
    check("rstx_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    check("rstx_done", {31'b0, bus.done}, 32'd0);
    check("rstx_rf_wr", {31'b0, bus.rf_wr}, 32'd0);
    rst = 1'b0;
    #1;
    check("rstx_ready_after", {31'b0, bus.in_ready}, 32'd1);
    check("rstx_done_after", {31'b0, bus.done}, 32'd0);
    check("rstx_wr_after", {31'b0, bus.rf_wr}, 32'd0);
`ifdef SEQ_FLAGS_EN
    check("rstx_flags", {28'b0, bus.flags}, 32'h0);
`endif

    // Back-to-back with in_valid held: accepts exactly 4 cycles apart
    b2b_instr[0] = enc(4'd8, 4'd1, 4'd0, 4'd0, 16'd5);
    b2b_instr[1] = enc(4'd1, 4'd1, 4'd1, 4'd1, 16'd0);
    b2b_instr[2] = enc(4'd1, 4'd2, 4'd1, 4'd1, 16'd0);
    b2b_exp[0]   = 32'd5;
    b2b_exp[1]   = 32'd10;
    b2b_exp[2]   = 32'd20;
    tick();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_instr = b2b_instr[k];
      check($sformatf("b2b%0d_ready_idle", k), {31'b0, bus.in_ready}, 32'd1);
      tick();
      if (k == 2) bus.in_valid = 1'b0;
      check($sformatf("b2b%0d_ready_read", k), {31'b0, bus.in_ready}, 32'd0);
      tick();
      check($sformatf("b2b%0d_ready_exec", k), {31'b0, bus.in_ready}, 32'd0);
      tick();
      check($sformatf("b2b%0d_ready_wb", k), {31'b0, bus.in_ready}, 32'd0);
      check($sformatf("b2b%0d_done", k), {31'b0, bus.done}, 32'd1);
      check($sformatf("b2b%0d_ip", k), bus.rf_ip, b2b_exp[k]);
      tick();
      if (k + 1 < 3) bus.in_instr = b2b_instr[k + 1];
    end
    tick();
    check("b2b_no_extra_accept", {31'b0, bus.in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
